adsr_envelope: RTL
==================

# adsr_envelope

ADSR amplitude envelope stage between the NCO and the I2S transmitter. Each 48 kHz tick it advances a 16-bit envelope level through attack, decay, sustain and release according to the key gate. It then scales the NCO sample by that level and presents the result to the transmitter. `env_active` drives the NCO's `nco_mute` (`nco_mute = !env_active`), so the oscillator keeps running through the release tail.

## Interface
- `ATTACK_STEP`, default 16'd64: level increment per tick in ATTACK. Must be ≥1.
- `DECAY_STEP`, default 16'd8: level decrement per tick in DECAY. Must be ≥1.
- `SUSTAIN_LEVEL`, default 16'hC000: hold level in SUSTAIN.
- `RELEASE_STEP`, default 16'd16: level decrement per tick in RELEASE. Must be ≥1.
- `master_clk`, in, 1: single clock for the block.
- `rst`, in, 1: reset, synchronous, active-high.
- `sample_clk_en`, in, 1: one-cycle 48 kHz tick strobe.
- `gate`, in, 1: key held; sampled only on tick edges.
- `sample_in`, in, signed 16: NCO sample output.
- `sample_out`, out, signed 16: enveloped sample.
- `sample_valid`, out, 1: one-cycle pulse when `sample_out` updates.
- `env_level`, out, 16: current unsigned envelope level.
- `env_state`, out, 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `env_active`, out, 1: high when `env_state != IDLE` (combinational from state).

## Operation
- Reset (`rst`=1 at a clock edge): `env_state`=IDLE, `env_level`=0, `sample_out`=0, `sample_valid`=0, internal sample register=0. Reset has priority over a coincident tick and applies mid-envelope or mid-multiply.
- State and level change only on edges where `sample_clk_en`=1. At each tick, evaluate in priority order:
  - ATTACK, DECAY or SUSTAIN with `gate`=0: go to RELEASE; level unchanged this tick.
  - IDLE: if `gate`=1, go to ATTACK with level unchanged (0). Otherwise stay IDLE with level 0.
  - ATTACK: compute 17-bit sum = level + `ATTACK_STEP`. If sum ≥ 65535, set level to 65535 and go to DECAY. Otherwise level = sum.
  - DECAY: compute 17-bit signed diff = level − `DECAY_STEP`. If diff ≤ `SUSTAIN_LEVEL`, set level to `SUSTAIN_LEVEL` and go to SUSTAIN. Otherwise level = diff.
  - SUSTAIN: level = `SUSTAIN_LEVEL`.
  - RELEASE, `gate`=1: retrigger. Go to ATTACK from the current level; level unchanged this tick.
  - RELEASE, `gate`=0: if level ≤ `RELEASE_STEP`, set level to 0 and go to IDLE. Otherwise level −= `RELEASE_STEP`.
- Sample path:
  - At each tick, capture `sample_in` into the sample register. This holds the NCO's previous, settled sample.
  - Product = `sample_reg` × signed{1'b0, level}, 33-bit signed, using the level after the tick update.
  - `sample_out` = product >>> 16 (arithmetic), truncated to 16 bits. No overflow is possible, because level < 65536.
- `sample_out` holds its value between updates. In IDLE it computes to 0 because the level is 0.

## Timing
- Tick edge T (`sample_clk_en`=1): `env_state`, `env_level` and the sample register update.
- Edge T+1: `sample_out` updates and `sample_valid`=1. At T+2, `sample_valid` returns to 0 unless T+1 was also a tick.
- Latency from tick to output is 2 edges. The NCO's output for tick T is consumed at tick T+1, giving one sample period of pipeline delay.
- Back-to-back ticks are legal; each is a full step.
- `gate` changes between ticks have no effect until the next tick.
- A gate pulse shorter than a tick period and missing a tick edge is ignored.

## Test plan
1. Reset and idle:
   - Stimulus: assert `rst` during SUSTAIN together with a tick; then release `rst` with `gate`=0 and run 10 ticks with `sample_in`=16'h7FFF.
   - Required: all outputs are 0, `env_state`=0 and `env_active`=0 throughout; `sample_out`=0 after every `sample_valid`.
2. Attack to decay (defaults):
   - Stimulus: raise `gate`.
   - Required: tick 1 gives ATTACK with level 0. After n further ticks, level=64n. n=1023 gives 65472. n=1024 gives 65535 and `env_state`=DECAY.
3. Decay to sustain:
   - Stimulus: continue from scenario 2.
   - Required: after 2047 decay ticks, level=49159. Tick 2048 gives level 49152 and SUSTAIN. Level then holds at 49152.
4. Scaling:
   - Level 65535, `sample_in`=16'h4000: required `sample_out`=16'h3FFF.
   - Level 65535, `sample_in`=16'h8000: required `sample_out`=16'h8000.
   - Level 49152, `sample_in`=16'h7FFF: required `sample_out`=16'h5FFF.
   - Timing for all: `sample_valid` pulses exactly one cycle, one edge after each tick.
5. Release and retrigger:
   - Stimulus: drop `gate` in SUSTAIN.
   - Required: the next tick gives RELEASE at 49152, then −16 per tick. After 3072 release ticks, IDLE with level 0 and `env_active` falls.
   - Stimulus: repeat, but re-raise `gate` at level 40000.
   - Required: the next tick gives ATTACK at 40000, then 40064, 40128, …
6. Early release:
   - Stimulus: drop `gate` after 10 attack ticks (level 640).
   - Required: RELEASE at 640, then 624, … reaching IDLE after 40 release ticks.

Source files
------------

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope between the NCO and the I2S transmitter.
// On each sample tick the envelope level steps through attack, decay, sustain
// and release according to the key gate. The registered NCO sample is then
// scaled by the level, and the result is presented one edge later.
module adsr_envelope #(
  parameter logic [15:0] ATTACK_STEP   = 16'd64,
  parameter logic [15:0] DECAY_STEP    = 16'd8,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [15:0] RELEASE_STEP  = 16'd16
) (
  input  logic               master_clk,
  input  logic               rst,
  input  logic               sample_clk_en,
  input  logic               gate,
  input  logic signed [15:0] sample_in,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic        [15:0] env_level,
  output logic        [2:0]  env_state,
  output logic               env_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  env_state_t         state;
  env_state_t         next_state;
  logic        [15:0] level;
  logic        [15:0] next_level;
  logic signed [15:0] sample_reg;
  logic               tick_q;
  logic        [16:0] attack_sum;
  logic signed [16:0] decay_diff;
  logic signed [32:0] product;
  logic               unused_product_bits;

  // The extra bit catches attack overshoot past full scale and decay
  // undershoot below zero, so neither step can wrap.
  assign attack_sum = {1'b0, level} + {1'b0, ATTACK_STEP};
  assign decay_diff = $signed({1'b0, level}) - $signed({1'b0, DECAY_STEP});

  // The level is kept non-negative by zero-extension. The top product bit
  // and the fractional bits do not reach the output.
  assign product             = sample_reg * $signed({1'b0, level});
  assign unused_product_bits = ^{product[32], product[15:0]};

  // Next-state and level rules, evaluated only on sample ticks.
  // A released gate wins over any rise/fall progress.
  always_comb begin
    next_state = state;
    next_level = level;
    if (sample_clk_en) begin
      case (state)
        ST_IDLE: begin
          next_level = '0;
          if (gate) next_state = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else if (attack_sum >= 17'd65535) begin
            next_level = 16'hFFFF;
            next_state = ST_DECAY;
          end else begin
            next_level = attack_sum[15:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else if (decay_diff <= $signed({1'b0, SUSTAIN_LEVEL})) begin
            next_level = SUSTAIN_LEVEL;
            next_state = ST_SUSTAIN;
          end else begin
            next_level = decay_diff[15:0];
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else begin
            next_level = SUSTAIN_LEVEL;
          end
        end
        ST_RELEASE: begin
          if (gate) begin
            next_state = ST_ATTACK;
          end else if (level <= RELEASE_STEP) begin
            next_level = '0;
            next_state = ST_IDLE;
          end else begin
            next_level = level - RELEASE_STEP;
          end
        end
        default: begin
          next_state = ST_IDLE;
          next_level = '0;
        end
      endcase
    end
  end

  // Envelope state, level and captured NCO sample advance together on a tick.
  // tick_q remembers that a tick happened so the product can be latched next edge.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      level      <= '0;
      sample_reg <= '0;
      tick_q     <= 1'b0;
    end else begin
      state  <= next_state;
      level  <= next_level;
      tick_q <= sample_clk_en;
      if (sample_clk_en) sample_reg <= sample_in;
    end
  end

  // Output stage: latch the scaled sample one edge after each tick and pulse valid.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_q;
      if (tick_q) sample_out <= product[31:16];
    end
  end

  assign env_level  = level;
  assign env_state  = state;
  assign env_active = (state != ST_IDLE);

endmodule
